// File: rtl/exec_unit.sv
// Single-issue execution unit: ALU ops retire one cycle after issue,
// MUL retires after a fixed EXEC latency, results offered on the CDB.
//
// Ports:
//   clk, rst (async, active-low)
//   issue_valid, op, val1, val2, target   : instruction from station
//   busy                                  : station must hold
//   cdb_valid, cdb_tag, cdb_data          : offered result
//   cdb_grant                             : arbiter accepts result
//   flush                                 : squash all in-flight work
module exec_unit #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 6,
    parameter int MUL_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [TAG_W-1:0]  target,
    output logic              busy,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant,
    input  logic              flush
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_CYC + 1);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;

    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_mul;
    logic [SH_W-1:0]   w_sh;
    logic              w_accept;

    assign w_sh  = val2[SH_W-1:0];
    assign w_mul = r_a * r_b;

    always_comb begin
        w_alu = '0;
        unique case (op)
            OP_ADD:  w_alu = val1 + val2;
            OP_SUB:  w_alu = val1 - val2;
            OP_AND:  w_alu = val1 & val2;
            OP_OR:   w_alu = val1 | val2;
            OP_XOR:  w_alu = val1 ^ val2;
            OP_SLL:  w_alu = val1 << w_sh;
            OP_SRL:  w_alu = val1 >> w_sh;
            OP_SRA:  w_alu = $signed(val1) >>> w_sh;
            OP_SLT:  w_alu = DATA_W'($signed(val1) < $signed(val2));
            OP_SLTU: w_alu = DATA_W'(val1 < val2);
            default: w_alu = '0;
        endcase
    end

    // WB with grant frees the unit in the same cycle for back-to-back issue
    assign busy = (r_state == S_EXEC) |
                  ((r_state == S_WB) & ~cdb_grant);

    assign w_accept = issue_valid & ~busy & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_tag <= target;
            if (op == OP_MUL) begin
                r_a     <= val1;
                r_b     <= val2;
                r_cnt   <= CNT_W'(MUL_CYC);
                r_valid <= 1'b0;
                r_state <= S_EXEC;
            end else begin
                r_data  <= w_alu;
                r_valid <= 1'b1;
                r_state <= S_WB;
            end
        end else begin
            unique case (r_state)
                S_EXEC: begin
                    // last EXEC cycle: product becomes the offered result
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_data  <= w_mul;
                        r_valid <= 1'b1;
                        r_state <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    if (cdb_grant) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_tag   = r_tag;
    assign cdb_data  = r_data;

endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit.
// Drives at posedge+1, checks registered outputs after the edge.
module tb_exec_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  op;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [4:0]  target;
    logic        busy;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    exec_unit #(
        .DATA_W (32),
        .TAG_W  (5),
        .OP_W   (6),
        .MUL_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .op         (op),
        .val1       (val1),
        .val2       (val2),
        .target     (target),
        .busy       (busy),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_grant  (cdb_grant),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic g,
                         input logic f);
        issue_valid = v;
        op          = o;
        val1        = a;
        val2        = b;
        target      = t;
        cdb_grant   = g;
        flush       = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue with grant held, so each result retires as the next is accepted
    task automatic alu_vec(input string name, input logic [5:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t, input logic [31:0] exp);
        drive(1'b1, o, a, b, t, 1'b1, 1'b0);
        tick();
        chk({name, "_v"}, 32'(cdb_valid), 32'd1);
        chk({name, "_tag"}, 32'(cdb_tag), 32'(t));
        chk({name, "_data"}, cdb_data, exp);
    endtask

    initial begin
        int stray;
        rst = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_tag",   32'(cdb_tag), 32'd0);
        chk("rst_data",  cdb_data, 32'd0);
        tick();
        rst = 1'b1;

        // ADD overflow, then retire to IDLE
        drive(1'b1, 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0);
        tick();
        chk("add_v",    32'(cdb_valid), 32'd1);
        chk("add_tag",  32'(cdb_tag), 32'd3);
        chk("add_data", cdb_data, 32'h8000_0000);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        #1;
        chk("add_busy_grant", 32'(busy), 32'd0);
        tick();
        chk("add_idle", 32'(cdb_valid), 32'd0);

        // back-to-back ALU stream
        alu_vec("sra",  6'd7, 32'h8000_0010, 32'h24, 5'd1, 32'hF800_0001);
        alu_vec("slt",  6'd8, 32'hFFFF_FFFF, 32'd1,  5'd2, 32'd1);
        alu_vec("sltu", 6'd9, 32'hFFFF_FFFF, 32'd1,  5'd4, 32'd0);
        alu_vec("sub",  6'd1, 32'd5, 32'd7, 5'd12, 32'hFFFF_FFFE);
        alu_vec("and",  6'd2, 32'hF0F0_FFFF, 32'h0FF0_00F0, 5'd13,
                32'h00F0_00F0);
        alu_vec("or",   6'd3, 32'hF000_0000, 32'h0000_000F, 5'd14,
                32'hF000_000F);
        alu_vec("xor",  6'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd15,
                32'h5555_5555);
        alu_vec("sll",  6'd5, 32'h0000_0003, 32'h0000_0101, 5'd16,
                32'h0000_0006);
        alu_vec("srl",  6'd6, 32'h8000_0000, 32'd31, 5'd17, 32'd1);
        alu_vec("bad",  6'd11, 32'h1234, 32'h5678, 5'd18, 32'd0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("stream_idle", 32'(cdb_valid), 32'd0);

        // MUL latency, grant held high while in EXEC
        drive(1'b1, 6'd10, 32'h0001_0001, 32'h0001_0001, 5'd7, 1'b1,
              1'b0);
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("mul_nv%0d", i), 32'(cdb_valid), 32'd0);
            tick();
        end
        chk("mul_v",    32'(cdb_valid), 32'd1);
        chk("mul_tag",  32'(cdb_tag), 32'd7);
        chk("mul_data", cdb_data, 32'h0002_0001);
        tick();
        chk("mul_idle", 32'(cdb_valid), 32'd0);

        // stall in WB, issue ignored, then back-to-back on grant
        drive(1'b1, 6'd0, 32'd10, 32'd20, 5'd5, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd0, 32'd1, 32'd1, 5'd6, 1'b0, 1'b0);
            #1;
            chk($sformatf("hold_v%0d", i), 32'(cdb_valid), 32'd1);
            chk($sformatf("hold_tag%0d", i), 32'(cdb_tag), 32'd5);
            chk($sformatf("hold_data%0d", i), cdb_data, 32'd30);
            chk($sformatf("hold_busy%0d", i), 32'(busy), 32'd1);
            tick();
        end
        chk("hold_tag_end", 32'(cdb_tag), 32'd5);
        drive(1'b1, 6'd0, 32'd1, 32'd1, 5'd6, 1'b1, 1'b0);
        tick();
        chk("b2b_v",    32'(cdb_valid), 32'd1);
        chk("b2b_tag",  32'(cdb_tag), 32'd6);
        chk("b2b_data", cdb_data, 32'd2);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("b2b_idle", 32'(cdb_valid), 32'd0);

        // flush during MUL EXEC cycle 2, with a competing issue
        drive(1'b1, 6'd10, 32'd3, 32'd3, 5'd8, 1'b0, 1'b0);
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'd0, 32'd1, 32'd2, 5'd9, 1'b1, 1'b1);
        tick();
        chk("fl_v",    32'(cdb_valid), 32'd0);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("fl_busy", 32'(busy), 32'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cdb_valid) stray++;
        end
        chk("fl_stray", 32'(stray), 32'd0);
        drive(1'b1, 6'd0, 32'd100, 32'd23, 5'd10, 1'b1, 1'b0);
        tick();
        chk("fl_add_v",    32'(cdb_valid), 32'd1);
        chk("fl_add_tag",  32'(cdb_tag), 32'd10);
        chk("fl_add_data", cdb_data, 32'd123);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();

        // async reset while in WB
        drive(1'b1, 6'd0, 32'd4, 32'd4, 5'd11, 1'b0, 1'b0);
        tick();
        chk("rwb_v", 32'(cdb_valid), 32'd1);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rwb_async_v", 32'(cdb_valid), 32'd0);
        chk("rwb_async_b", 32'(busy), 32'd0);
        chk("rwb_async_d", cdb_data, 32'd0);
        tick();
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cdb_valid) stray++;
        end
        chk("rwb_stray", 32'(stray), 32'd0);
        drive(1'b1, 6'd0, 32'd9, 32'd9, 5'd19, 1'b1, 1'b0);
        tick();
        chk("rwb_add_v",    32'(cdb_valid), 32'd1);
        chk("rwb_add_data", cdb_data, 32'd18);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
